// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 3:1 selector and caps
// how long any one requester may hold the path while another is waiting.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             req_c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             gnt_c,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  // Requester ids double as the {s1,s0} select code; NONE is the idle code.
  typedef enum logic [1:0] {
    ID_A    = 2'b00,
    ID_B    = 2'b01,
    ID_C    = 2'b10,
    ID_NONE = 2'b11
  } id_t;

  localparam int unsigned    HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0]  HOLD_ONE = HW'(1);

  state_t        r_state;
  id_t           r_owner;
  id_t           r_last;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_gnt;

  logic [2:0]    w_req;
  logic [2:0]    w_owner_mask;
  logic [2:0]    w_others;
  logic          w_owner_req;
  logic          w_take;
  id_t           w_pick;
  state_t        w_nxt_state;
  id_t           w_nxt_owner;
  id_t           w_nxt_last;
  logic [HW-1:0] w_nxt_hold;
  logic [2:0]    w_nxt_gnt;

  // First requester in rotating order, starting just after the last-served one.
  function automatic id_t f_pick(input logic [2:0] req, input id_t last);
    id_t         win;
    int unsigned idx;
    logic [1:0]  sel;
    win = ID_NONE;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = (32'(last) + k) % 3;
      sel = idx[1:0];
      if (win == ID_NONE && req[sel]) win = id_t'(sel);
    end
    return win;
  endfunction

  assign w_req = {req_c, req_b, req_a};

  always_comb begin
    w_owner_mask = '0;
    case (r_owner)
      ID_A:    w_owner_mask = 3'b001;
      ID_B:    w_owner_mask = 3'b010;
      ID_C:    w_owner_mask = 3'b100;
      default: w_owner_mask = '0;
    endcase
  end

  // With the owner masked out, one pick serves idle arbitration, handover and rotation.
  assign w_others    = w_req & ~w_owner_mask;
  assign w_owner_req = |(w_req & w_owner_mask);
  assign w_pick      = f_pick(w_others, r_last);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_hold  = r_hold;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) w_take = 1'b1;
      end
      ST_BUSY: begin
        if (w_owner_req) begin
          if (|w_others && r_hold == HOLD_MAX) begin
            w_take = 1'b1;
          end else if (|w_others) begin
            // Reaching the cap under contention always rotates, so this never wraps.
            w_nxt_hold = r_hold + HOLD_ONE;
          end else begin
            w_nxt_hold = HOLD_ONE;
          end
        end else if (|w_others) begin
          w_take = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_owner = ID_NONE;
          w_nxt_hold  = '0;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_owner = ID_NONE;
        w_nxt_hold  = '0;
      end
    endcase
    if (w_take) begin
      w_nxt_state = ST_BUSY;
      w_nxt_owner = w_pick;
      w_nxt_last  = w_pick;
      w_nxt_hold  = HOLD_ONE;
    end
  end

  always_comb begin
    w_nxt_gnt = '0;
    case (w_nxt_owner)
      ID_A:    w_nxt_gnt = 3'b001;
      ID_B:    w_nxt_gnt = 3'b010;
      ID_C:    w_nxt_gnt = 3'b100;
      default: w_nxt_gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= ID_NONE;
      r_last  <= ID_C;
      r_hold  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_hold  <= w_nxt_hold;
      r_gnt   <= w_nxt_gnt;
    end
  end

  assign {gnt_c, gnt_b, gnt_a} = r_gnt;
  assign s0      = r_owner[0];
  assign s1      = r_owner[1];
  assign y_valid = |r_gnt;

  always_comb begin
    y = '0;
    case (r_owner)
      ID_A:    y = a;
      ID_B:    y = b;
      ID_C:    y = c;
      default: y = '0;
    endcase
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
  a_sel_idle:   assert property (@(posedge clk) disable iff (!rst_n)
                                 ((r_gnt == 3'b000) == (r_owner == ID_NONE)));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: rule-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic         req_c = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic         gnt_a, gnt_b, gnt_c, s0, s1, y_valid;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Model: owner index 0=A 1=B 2=C, -1 = nobody.
  int m_owner = -1;
  int m_last  = 2;
  int m_hold  = 0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .a(a), .b(b), .c(c),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .s0(s0), .s1(s1), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  function automatic int pick(bit [2:0] r, int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(bit [2:0] r);
    bit [2:0] others;
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    if (m_owner < 0) begin
      if (r != 3'b000) begin
        m_owner = pick(r, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end
    end else if (r[m_owner]) begin
      if (others != 3'b000 && m_hold == MH) begin
        m_owner = pick(others, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end else if (others != 3'b000) begin
        m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
      end else begin
        m_hold = 1;
      end
    end else if (others != 3'b000) begin
      m_owner = pick(others, m_last);
      m_last  = m_owner;
      m_hold  = 1;
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 2;
      m_hold  = 0;
    end else begin
      model_step({req_c, req_b, req_a});
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic lit(string tag, logic [2:0] g, logic [1:0] s, logic [W-1:0] yy, logic v);
    chk({tag, "_gnt"}, 32'({gnt_c, gnt_b, gnt_a}), 32'(g));
    chk({tag, "_sel"}, 32'({s1, s0}), 32'(s));
    chk({tag, "_y"}, 32'(y), 32'(yy));
    chk({tag, "_vld"}, 32'(y_valid), 32'(v));
  endtask

  always @(posedge clk) begin
    #3;
    if (!done) begin
      logic [2:0]   eg;
      logic [1:0]   es;
      logic [W-1:0] ey;
      if (m_owner < 0) begin
        eg = 3'b000; es = 2'b11; ey = '0;
      end else begin
        eg = 3'b001 << m_owner;
        es = 2'(m_owner);
        ey = (m_owner == 0) ? a : (m_owner == 1) ? b : c;
      end
      chk("model_gnt", 32'({gnt_c, gnt_b, gnt_a}), 32'(eg));
      chk("model_sel", 32'({s1, s0}), 32'(es));
      chk("model_y", 32'(y), 32'(ey));
      chk("model_vld", 32'(y_valid), 32'(m_owner >= 0));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(); lit("rst0", 3'b000, 2'b11, '0, 1'b0);
    tick(); lit("rst1", 3'b000, 2'b11, '0, 1'b0);
    rst_n = 1'b1; a = '1; b = '1; c = '1;
    repeat (3) begin tick(); lit("idle_ones", 3'b000, 2'b11, '0, 1'b0); end

    a = 4'h1; b = 4'h2; c = 4'h4;
    req_a = 1'b1;
    tick(); lit("single_a", 3'b001, 2'b00, 4'h1, 1'b1);
    req_a = 1'b0;
    tick(); lit("single_drop", 3'b000, 2'b11, '0, 1'b0);

    rst_n = 1'b0; #1; lit("rst_pulse", 3'b000, 2'b11, '0, 1'b0); rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    tick(); lit("sim_a", 3'b001, 2'b00, 4'h1, 1'b1);
    req_a = 1'b0;
    tick(); lit("sim_b", 3'b010, 2'b01, 4'h2, 1'b1);
    req_b = 1'b0;
    tick(); lit("sim_c", 3'b100, 2'b10, 4'h4, 1'b1);
    req_c = 1'b0;
    tick(); lit("sim_idle", 3'b000, 2'b11, '0, 1'b0);

    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_a = 1'b1;
    tick(); lit("hold_a1", 3'b001, 2'b00, 4'h1, 1'b1);
    req_c = 1'b1;
    repeat (3) begin tick(); lit("hold_a", 3'b001, 2'b00, 4'h1, 1'b1); end
    tick(); lit("rot_c", 3'b100, 2'b10, 4'h4, 1'b1);
    c = 4'h9;
    repeat (3) begin tick(); lit("hold_c", 3'b100, 2'b10, 4'h9, 1'b1); end
    tick(); lit("rot_a", 3'b001, 2'b00, 4'h1, 1'b1);
    req_a = 1'b0; req_c = 1'b0;
    tick(); lit("fair_idle", 3'b000, 2'b11, '0, 1'b0);

    c = 4'h4;
    req_b = 1'b1;
    tick(); lit("own_b", 3'b010, 2'b01, 4'h2, 1'b1);
    req_c = 1'b1;
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 3'b000, 2'b11, '0, 1'b0);
    tick(); lit("in_rst", 3'b000, 2'b11, '0, 1'b0);
    rst_n = 1'b1;
    tick(); lit("post_rst_b", 3'b010, 2'b01, 4'h2, 1'b1);
    req_c = 1'b0;
    repeat (8) begin tick(); lit("sole_b", 3'b010, 2'b01, 4'h2, 1'b1); end
    req_b = 1'b0;
    tick(); lit("sole_idle", 3'b000, 2'b11, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      if ($urandom_range(0, 3) == 0) req_c = ~req_c;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      if (i == 200) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end
    end
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    tick(); tick();
    lit("end_idle", 3'b000, 2'b11, '0, 1'b0);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 3:1 selector datapath (inputs a, b, c; selects s0/s1; output y) between three requesters, A, B and C.
- Arbitrates requests with rotating (round-robin) priority and drives the select lines from registered state.
- Caps how long any one requester may hold the path.
- Sits in front of the existing selector so that upstream sources no longer drive s0/s1 directly.

Parameters:
- WIDTH, 1, width of each data input and of y.
- MAX_HOLD, 4, maximum consecutive cycles one grant may last while another requester is waiting (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A wants the path.
- req_b  input  1  requester B wants the path.
- req_c  input  1  requester C wants the path.
- a  input  WIDTH  data from A.
- b  input  WIDTH  data from B.
- c  input  WIDTH  data from C.
- gnt_a  output  1  A owns the path (registered).
- gnt_b  output  1  B owns the path (registered).
- gnt_c  output  1  C owns the path (registered).
- s0  output  1  select bit 0 (registered).
- s1  output  1  select bit 1 (registered).
- y  output  WIDTH  selected data (combinational from a/b/c and registered selects).
- y_valid  output  1  y carries granted data (equals OR of grants).

Behaviour:
- Select encoding {s1,s0}:
  - 00 = a, 01 = b, 10 = c.
  - 11 = idle; y is forced to all-zero.
- Reset (rst_n low, asynchronous):
  - gnt_a/b/c = 0, {s1,s0} = 11, y = 0, y_valid = 0.
  - Internal: last-served pointer = C (so A has first priority), hold counter = 0, state = IDLE.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States:
  - IDLE: no grant.
  - BUSY: exactly one grant; the grant vector is always one-hot or zero.
- Priority order: starts at the requester after the last-served one. Last = A gives B, C, A; last = B gives C, A, B; last = C gives A, B, C.
- IDLE transitions:
  - If any req is high at a clock edge, go to BUSY on that edge.
  - Grant the highest-priority requester, update {s1,s0}, load hold counter = 1, set last-served to the winner.
  - Latency: req sampled at edge n gives gnt/selects/y_valid valid after edge n.
- BUSY, owner's req still high:
  - If another req is pending and hold counter == MAX_HOLD: rotate. The next-priority requester (excluding the owner) is granted directly on that edge, with no idle bubble, and the counter is reloaded to 1.
  - Otherwise keep the grant. The counter increments only while another requester is waiting; it saturates at MAX_HOLD and is reset to 1 when no other requester is waiting.
- BUSY, owner's req low at an edge:
  - If another req is high, hand over on the same edge (as in IDLE arbitration) with no bubble.
  - Otherwise go to IDLE: grants 0, selects 11, y_valid 0.
- Simultaneous requests from several requesters: resolved purely by rotating priority.
- The owner dropping req and re-raising it on the same edge is not possible; sampling is per edge.
- A sole requester holds the path indefinitely; the MAX_HOLD cap applies only under contention.
- y follows live a/b/c data of the owner combinationally; no data register.

Test Plan:
- Reset then idle:
  - rst_n=0 for 2 cycles, all req=0 → gnt=000, {s1,s0}=11, y=0, y_valid=0.
  - Release rst_n with all req=0 for 3 cycles → outputs unchanged.
- Single requester:
  - req_a=1 with a=1 → after next edge gnt_a=1, {s1,s0}=00, y=1, y_valid=1.
  - Drop req_a → after next edge idle, selects 11.
- Simultaneous requests:
  - req_a=req_b=req_c=1 from reset, each requester dropping its req one cycle after being granted → grants in order A, B, C.
  - Selects step 00 → 01 → 10, with no idle cycle between grants.
- MAX_HOLD=4 fairness:
  - req_a held high, req_c raised 1 cycle after gnt_a → gnt_a lasts exactly 4 cycles, then gnt_c with {s1,s0}=10 and c routed to y.
  - req_a still high → A is regranted after C holds 4 cycles.
- Async reset mid-grant:
  - gnt_b=1, pull rst_n low between clock edges → gnt_b=0, selects 11 and y_valid=0 immediately.
  - After release with req_b=req_c=1 → A has first priority but is absent, so B is granted.
- Idle encoding:
  - Force a=b=c=all-ones while no req → y=0 throughout.
